exec_alu_unit: RTL

- Consumer of the exec_unit_params bundle produced by decode.
- Selects operands (register, PC or immediate), performs the RV32I ALU operation and returns a registered result through a valid/ready handshake toward writeback.
- Shifts are iterative (one bit per cycle); all other ops take one cycle.
- Sits between decode/register-read and the writeback/branch logic.

---
 rtl/exec_unit_pkg.sv | 44 ++++
 rtl/exec_alu_unit_if.sv | 29 ++
 rtl/alu_shift_iter.sv | 66 ++++++
 rtl/exec_alu_unit.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// Shared types for the execute ALU: op encoding, operand selects, the decode
// parameter bundle and the controller state type.
package exec_unit_pkg;

  // {bit3, funct3}; bit3 only matters for funct3 000 (SUB) and 101 (SRA)
  typedef logic [3:0] exec_op_t;

  localparam exec_op_t EXEC_OP_ADD  = 4'b0000;
  localparam exec_op_t EXEC_OP_SUB  = 4'b1000;
  localparam exec_op_t EXEC_OP_SLL  = 4'b0001;
  localparam exec_op_t EXEC_OP_SLT  = 4'b0010;
  localparam exec_op_t EXEC_OP_SLTU = 4'b0011;
  localparam exec_op_t EXEC_OP_XOR  = 4'b0100;
  localparam exec_op_t EXEC_OP_SRL  = 4'b0101;
  localparam exec_op_t EXEC_OP_SRA  = 4'b1101;
  localparam exec_op_t EXEC_OP_OR   = 4'b0110;
  localparam exec_op_t EXEC_OP_AND  = 4'b0111;

  typedef enum logic {
    OP1_SEL_RS1 = 1'b0,
    OP1_SEL_PC  = 1'b1
  } op1_sel_t;

  typedef enum logic {
    OP2_SEL_RS2 = 1'b0,
    OP2_SEL_IMM = 1'b1
  } op2_sel_t;

  typedef struct packed {
    exec_op_t exec_op;
    op1_sel_t operand1_sel;
    op2_sel_t operand2_sel;
  } exec_unit_params;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_t;

  function automatic logic is_shift_op(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/exec_alu_unit_if.sv
// Decode-to-ALU request side and ALU-to-writeback result side, one bundle.
interface exec_alu_unit_if #(
  parameter int XLEN = 32
) ();
  import exec_unit_pkg::*;

  logic            in_valid;
  logic            in_ready;
  exec_unit_params params;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, params, rs1_val, rs2_val, pc, imm, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, params, rs1_val, rs2_val, pc, imm, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/alu_shift_iter.sv
// One-bit-per-cycle shifter: loads on start, shifts while busy, pulses done
// in the cycle whose shift produces the final value (presented on shifted).
module alu_shift_iter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [XLEN-1:0]    op_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir_right,
  input  logic               arith,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    shifted
);

  logic [XLEN-1:0]    work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               dir_q, dir_d;
  logic               arith_q, arith_d;

  always_comb begin
    shifted = dir_q ? {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]}
                    : {work_q[XLEN-2:0], 1'b0};
    done    = busy_q && (cnt_q == SHAMT_W'(1));

    work_d  = work_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    if (start) begin
      work_d  = op_in;
      cnt_d   = shamt;
      busy_d  = 1'b1;
      dir_d   = dir_right;
      arith_d = arith;
    end else if (busy_q) begin
      work_d = shifted;
      cnt_d  = cnt_q - 1'b1;
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/exec_alu_unit.sv
// RV32I execute ALU with registered valid/ready result. FAST_SHIFT_EN selects a
// single-cycle barrel shifter instead of the iterative alu_shift_iter.
//   state    | meaning
//   ST_IDLE  | accepting ops; single-cycle results land here
//   ST_SHIFT | iterative shift running, input held off
module exec_alu_unit
  import exec_unit_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  exec_alu_unit_if.slave bus
);

  logic [3:0]             op_bits;
  logic [2:0]             funct3;
  logic                   bit3;
  logic [XLEN-1:0]        op1, op2, alu_res;
  logic signed [XLEN-1:0] sra_val;
  logic [SHAMT_W-1:0]     shamt;
  logic                   is_shift;
  logic                   in_ready;
  logic                   accept;
  logic                   out_valid_q, out_valid_d;
  logic [XLEN-1:0]        result_q, result_d;

  always_comb begin
    op_bits  = bus.params.exec_op;
    funct3   = op_bits[2:0];
    bit3     = op_bits[3];
    op1      = (bus.params.operand1_sel == OP1_SEL_PC)  ? bus.pc  : bus.rs1_val;
    op2      = (bus.params.operand2_sel == OP2_SEL_IMM) ? bus.imm : bus.rs2_val;
    shamt    = op2[SHAMT_W-1:0];
    is_shift = is_shift_op(funct3);
    sra_val  = $signed(op1) >>> shamt;

    alu_res = '0;
    case (funct3)
      3'b000: alu_res = bit3 ? (op1 - op2) : (op1 + op2);
      3'b010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
      3'b011: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
      3'b100: alu_res = op1 ^ op2;
      3'b110: alu_res = op1 | op2;
      3'b111: alu_res = op1 & op2;
`ifdef FAST_SHIFT_EN
      3'b001: alu_res = op1 << shamt;
      3'b101: alu_res = bit3 ? sra_val : (op1 >> shamt);
`else
      // only the zero-amount case completes here; longer shifts go iterative
      3'b001, 3'b101: alu_res = op1;
`endif
    endcase
  end

  assign accept = bus.in_valid && in_ready;

`ifdef FAST_SHIFT_EN

  assign in_ready = !out_valid_q || bus.out_ready;
  assign bus.busy = 1'b0;

  always_comb begin
    out_valid_d = out_valid_q && !bus.out_ready;
    result_d    = result_q;
    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

`else

  alu_state_t      state_q, state_d;
  logic            shift_start, shift_busy, shift_done;
  logic [XLEN-1:0] shift_val;

  assign in_ready    = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign shift_start = accept && is_shift && (shamt != '0);
  assign bus.busy    = shift_busy;

  alu_shift_iter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (shift_start),
    .op_in     (op1),
    .shamt     (shamt),
    .dir_right (funct3[2]),
    .arith     (bit3),
    .busy      (shift_busy),
    .done      (shift_done),
    .shifted   (shift_val)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    result_d    = result_q;
    case (state_q)
      ST_IDLE: begin
        if (shift_start) begin
          state_d = ST_SHIFT;
        end else if (accept) begin
          out_valid_d = 1'b1;
          result_d    = alu_res;
        end
      end
      ST_SHIFT: begin
        if (shift_done) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b1;
          result_d    = shift_val;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule
